// File: rtl/ssb_pkg.sv
// Shared types, sizes and the saturating extraction helper for the SSB modulator.
package ssb_pkg;

    localparam int W     = 24;
    localparam int M     = 16;
    localparam int TAPS  = 51;
    localparam int ACC_W = 46;
    localparam int O     = 38;
    localparam int DELAY = (TAPS - 1) / 2;
    localparam int PTR_W = $clog2(TAPS);
    localparam int P_W   = W + M;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    function automatic logic [W-1:0] sat_w(input logic [ACC_W-1:0] acc);
        logic [ACC_W-O-1:0] hi;
        hi = acc[ACC_W-1:O];
        if (hi == '0 || hi == '1) begin
            return acc[O:O-W+1];
        end
        if (acc[ACC_W-1]) begin
            return {1'b1, {(W-1){1'b0}}};
        end
        return {1'b0, {(W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/ssb_sample_ring.sv
// Circular Q history with one write port and a registered read port.
// Reads are addressed as an offset behind the write pointer, wrapped mod TAPS.
module ssb_sample_ring
    import ssb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             adv,
    input  logic [PTR_W-1:0] rd_off,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0]     mem_q [TAPS];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_addr;
    logic [W-1:0]     rd_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (adv) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        // TAPS is not a power of two, so the wrap is explicit
        if (wr_ptr_q >= rd_off) begin
            rd_addr = wr_ptr_q - rd_off;
        end else begin
            rd_addr = wr_ptr_q + PTR_W'(TAPS) - rd_off;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ssb_mac_scheduler.sv
// SSB modulator sequencer: one shared MAC runs the Hilbert FIR on Q,
// then combines it with the delayed I sample into an LSB/USB output.
module ssb_mac_scheduler
    import ssb_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next_lrclk_fall,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] q_in,
    input  logic         usb,
    output logic [7:0]   coef_addr,
    input  logic [M-1:0] coef_data,
    output logic [W-1:0] ssb_out,
    output logic         ssb_valid,
    output logic         busy,
    output logic         overrun
);

    state_t           state_q, state_d;
    logic [7:0]       coef_addr_q, coef_addr_d;
    logic             usb_q, usb_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [P_W-1:0]   prod_q, prod_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [W-1:0]     dl_q [DELAY+1];
    logic [W-1:0]     dl_d [DELAY+1];
    logic [W-1:0]     out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic [W-1:0]     q_rd;
    logic [W-1:0]     hq;
    logic [W-1:0]     di;
    logic             accept;

    assign accept = (state_q == IDLE) && next_lrclk_fall;
    assign di     = dl_q[DELAY];

    ssb_sample_ring u_q_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_data (q_in),
        .adv     (state_q == OUT),
        .rd_off  (coef_addr_q[PTR_W-1:0]),
        .rd_data (q_rd)
    );

    always_comb begin
        state_d     = state_q;
        coef_addr_d = coef_addr_q;
        usb_d       = usb_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        dl_d        = dl_q;
        out_d       = out_q;
        v1_d        = (state_q == MAC);
        v2_d        = v1_q;
        ovr_d       = ovr_q | (next_lrclk_fall && state_q != IDLE);

        // ROM/ring read -> product register -> accumulate
        if (v1_q) begin
            prod_d = $signed(coef_data) * $signed(q_rd);
        end
        if (v2_q) begin
            acc_d = acc_q + {{(ACC_W-P_W){prod_q[P_W-1]}}, prod_q};
        end
        hq = sat_w(acc_d);

        unique case (state_q)
            IDLE: begin
                if (next_lrclk_fall) begin
                    state_d     = MAC;
                    coef_addr_d = '0;
                    usb_d       = usb;
                    acc_d       = '0;
                    dl_d[0]     = i_in;
                    for (int i = 1; i <= DELAY; i++) begin
                        dl_d[i] = dl_q[i-1];
                    end
                end
            end
            MAC: begin
                if (coef_addr_q == 8'(TAPS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    coef_addr_d = coef_addr_q + 8'd1;
                end
            end
            DRAIN: begin
                // second drain cycle: the final product lands in acc_d now
                if (!v1_q) begin
                    state_d = OUT;
                    if (usb_q) begin
                        out_d = W'(({di[W-1], di} - {hq[W-1], hq}) >> 1);
                    end else begin
                        out_d = W'(({di[W-1], di} + {hq[W-1], hq}) >> 1);
                    end
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == OUT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            coef_addr_q <= '0;
            usb_q       <= 1'b0;
            acc_q       <= '0;
            prod_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            for (int i = 0; i <= DELAY; i++) begin
                dl_q[i] <= '0;
            end
            out_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_addr_q <= coef_addr_d;
            usb_q       <= usb_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            dl_q        <= dl_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign coef_addr = coef_addr_q;
    assign ssb_out   = out_q;
    assign ssb_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_ssb_mac_scheduler.sv
// Bench for ssb_mac_scheduler: directed scenarios plus randomized samples
// checked against a sample-history model of the FIR and sideband mix.
module tb_ssb_mac_scheduler;

    localparam int TAPS  = 51;
    localparam int DELAY = 25;
    localparam int LAT   = 54;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        next_lrclk_fall = 1'b0;
    logic [23:0] i_in = '0;
    logic [23:0] q_in = '0;
    logic        usb = 1'b0;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data = '0;
    logic [23:0] ssb_out;
    logic        ssb_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] h [256];
    longint      qhist [TAPS];
    longint      ihist [DELAY+1];
    int          total = 0;
    int          bad = 0;

    ssb_mac_scheduler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .next_lrclk_fall (next_lrclk_fall),
        .i_in            (i_in),
        .q_in            (q_in),
        .usb             (usb),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .ssb_out         (ssb_out),
        .ssb_valid       (ssb_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coef_data <= h[coef_addr];

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) qhist[k] = 0;
        for (int k = 0; k <= DELAY; k++) ihist[k] = 0;
    endfunction

    // y[n] = (i[n-DELAY] +/- clamp(floor(sum h[k]q[n-k] / 2^15))) / 2, floored
    function automatic logic [23:0] model_step(input logic [23:0] i, input logic [23:0] q,
                                               input logic u);
        longint acc, hqv, s;
        for (int k = TAPS - 1; k > 0; k--) qhist[k] = qhist[k-1];
        for (int k = DELAY; k > 0; k--) ihist[k] = ihist[k-1];
        qhist[0] = longint'($signed(q));
        ihist[0] = longint'($signed(i));
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'($signed(h[k])) * qhist[k];
        hqv = acc >>> 15;
        if (hqv > 8388607) hqv = 8388607;
        if (hqv < -8388608) hqv = -8388608;
        s = u ? ihist[DELAY] - hqv : ihist[DELAY] + hqv;
        s = s >>> 1;
        return s[23:0];
    endfunction

    task automatic set_h_zero();
        for (int k = 0; k < 256; k++) h[k] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        next_lrclk_fall = 1'b0;
        usb = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input logic [23:0] i, input logic [23:0] q, input logic u,
                        input logic u_busy, output logic [23:0] got, output int lat);
        @(negedge clk);
        i_in = i;
        q_in = q;
        usb = u;
        next_lrclk_fall = 1'b1;
        lat = -1;
        got = 'x;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                next_lrclk_fall = 1'b0;
                usb = u_busy;
                i_in = 24'($urandom);
                q_in = 24'($urandom);
            end
            if (ssb_valid) begin
                lat = c;
                got = ssb_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [23:0] got, exp, i, q;
        logic u;
        int lat;
        set_h_zero();
        for (int k = 0; k < TAPS; k++) h[k] = 16'($urandom);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({ssb_out, ssb_valid, busy, overrun, coef_addr} !== '0) begin
            bad++;
            $display("FAIL reset_init: out=%h v=%b b=%b o=%b a=%h want all 0",
                     ssb_out, ssb_valid, busy, overrun, coef_addr);
        end
        do_reset();
        for (int n = 0; n < 3; n++) begin
            i = 24'($urandom); q = 24'($urandom); u = 1'($urandom);
            send(i, q, u, ~u, got, lat);
            exp = model_step(i, q, u);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL reset_pre n=%0d: got %h want %h", n, got, exp);
            end
        end
        @(negedge clk);
        i_in = 24'($urandom); q_in = 24'($urandom); next_lrclk_fall = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            next_lrclk_fall = (c == 5);
        end
        total++;
        if (busy !== 1'b1 || coef_addr !== 8'd9 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL mid_mac: busy=%b addr=%0d ovr=%b want 1 9 1", busy, coef_addr, overrun);
        end
        reset_n = 1'b0;
        next_lrclk_fall = 1'b0;
        #1;
        total++;
        if ({ssb_out, ssb_valid, busy, overrun, coef_addr} !== '0) begin
            bad++;
            $display("FAIL reset_mid: out=%h v=%b b=%b o=%b a=%h want all 0",
                     ssb_out, ssb_valid, busy, overrun, coef_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        i = 24'($urandom); q = 24'($urandom);
        send(i, q, 1'b0, 1'b1, got, lat);
        exp = model_step(i, q, 1'b0);
        total++;
        if (got !== exp || lat != LAT) begin
            bad++; $display("FAIL reset_fresh: got %h lat %0d want %h lat %0d", got, lat, exp, LAT);
        end
    endtask

    task automatic test_q_impulse();
        logic [23:0] got, exp;
        int lat;
        set_h_zero();
        h[25] = 16'sh4000;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            send(24'h0, (n == 0) ? 24'h200000 : 24'h0, 1'b0, 1'b1, got, lat);
            exp = (n == 25) ? 24'h080000 : 24'h0;
            total++;
            if (got !== exp || lat != LAT) begin
                bad++;
                $display("FAIL q_impulse n=%0d: got %h lat %0d want %h lat %0d", n, got, lat, exp, LAT);
            end
        end
        total++;
        if (coef_addr !== 8'd50) begin
            bad++; $display("FAIL coef_hold: got %0d want 50", coef_addr);
        end
    endtask

    task automatic test_i_delay();
        logic [23:0] got, exp;
        int lat;
        set_h_zero();
        for (int u = 0; u < 2; u++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                send((n == 0) ? 24'h200000 : 24'h0, 24'h0, u[0], ~u[0], got, lat);
                exp = (n == 25) ? 24'h100000 : 24'h0;
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL i_delay u=%0d n=%0d: got %h want %h", u, n, got, exp);
                end
            end
        end
    endtask

    task automatic test_sideband();
        logic [23:0] got, exp;
        longint hqv, dv;
        int lat;
        set_h_zero();
        h[25] = 16'sh4000;
        for (int u = 0; u < 2; u++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                send(24'h100000, 24'h100000, u[0], ~u[0], got, lat);
                dv  = (n >= DELAY) ? 64'sh100000 : 0;
                hqv = (n >= 25) ? (64'sh100000 * 16384) >>> 15 : 0;
                exp = 24'(u ? (dv - hqv) >>> 1 : (dv + hqv) >>> 1);
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL sideband u=%0d n=%0d: got %h want %h", u, n, got, exp);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] got, exp, v;
        logic u;
        int lat;
        set_h_zero();
        for (int k = 0; k < TAPS; k++) h[k] = 16'sh7FFF;
        for (int p = 0; p < 3; p++) begin
            do_reset();
            v = (p == 1) ? 24'h800000 : 24'h7FFFFF;
            u = (p == 2);
            for (int n = 0; n < 30; n++) begin
                send(v, v, u, ~u, got, lat);
                exp = model_step(v, v, u);
                if (p == 0 && n >= DELAY) exp = 24'h7FFFFF;
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL saturation p=%0d n=%0d: got %h want %h", p, n, got, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] got, exp, i, q;
        logic u;
        int lat;
        set_h_zero();
        for (int k = 0; k < TAPS; k++) h[k] = 16'($urandom);
        do_reset();
        for (int n = 0; n < 60; n++) begin
            i = 24'($urandom); q = 24'($urandom); u = 1'($urandom);
            send(i, q, u, 1'($urandom), got, lat);
            exp = model_step(i, q, u);
            total++;
            if (got !== exp || lat != LAT) begin
                bad++;
                $display("FAIL random n=%0d: got %h lat %0d want %h lat %0d", n, got, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_overrun_timing();
        logic [23:0] exp_out, i, q;
        logic u, exp_busy, exp_v, exp_ovr;
        int last_acc;
        set_h_zero();
        for (int k = 0; k < TAPS; k++) h[k] = 16'($urandom);
        do_reset();
        last_acc = -1;
        exp_ovr = 1'b0;
        exp_out = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            exp_busy = (last_acc >= 0) && (cyc > last_acc) && (cyc <= last_acc + LAT);
            exp_v = (last_acc >= 0) && (cyc == last_acc + LAT);
            total++;
            if (busy !== exp_busy || ssb_valid !== exp_v || overrun !== exp_ovr) begin
                bad++;
                $display("FAIL timing cyc=%0d: b/v/o=%b%b%b want %b%b%b",
                         cyc, busy, ssb_valid, overrun, exp_busy, exp_v, exp_ovr);
            end
            if (exp_v) begin
                total++;
                if (ssb_out !== exp_out) begin
                    bad++; $display("FAIL timing_out cyc=%0d: got %h want %h", cyc, ssb_out, exp_out);
                end
            end
            i = 24'($urandom); q = 24'($urandom); u = 1'($urandom);
            i_in = i; q_in = q; usb = u;
            next_lrclk_fall = (cyc % 20 == 0);
            if (cyc % 20 == 0) begin
                if (last_acc < 0 || cyc >= last_acc + LAT + 1) begin
                    last_acc = cyc;
                    exp_out = model_step(i, q, u);
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
        @(negedge clk);
        next_lrclk_fall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_q_impulse();
        test_i_delay();
        test_sideband();
        test_saturation();
        test_random();
        test_overrun_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
